// File: rtl/mips_pkg.sv
// Shared pipeline types for the MIPS datapath: ID/EX control bundle and register constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Width of the ALUOp field carried in the control bundle.
    localparam int CTRL_ALUOP_W = 3;

    // Architectural zero register; never a real producer, so it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Decoded control that travels with an instruction from ID into EX.
    typedef struct packed {
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    alu_src;
        logic                    branch;
        logic [CTRL_ALUOP_W-1:0] alu_op;
    } id_ex_ctrl_t;

    // A bubble carries no side effects: every control bit cleared.
    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a load in EX is about to write.
// Latency: purely combinational.
// Backpressure: its Stall output is the hold request for PC and IF/ID (IF/ID write enable is ~stall).
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             stall
);

    logic rt_match;

    // A load into $0 writes nothing, so it can never feed a dependent instruction.
    always_comb begin
        rt_match = (ex_rt != REG_W'(REG_ZERO)) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        stall    = ex_valid && ex_mem_read && id_valid && rt_match;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection; optional stall counter under STALL_COUNT_EN.
// Latency: one cycle from ID inputs to ID_EX outputs; Stall is combinational from current EX/ID contents.
// Backpressure: on a load-use hazard Stall holds PC and IF/ID and a bubble enters EX; Flush overrides Stall.
module id_ex_stage_reg
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 3,
    parameter int REG_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Flush,
    input  logic               IF_ID_Valid,
    input  logic [REG_W-1:0]   IF_ID_Rs,
    input  logic [REG_W-1:0]   IF_ID_Rt,
    input  logic [REG_W-1:0]   ID_Rd,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_ALUSrc,
    input  logic               ID_Branch,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [DATA_W-1:0]  ID_PC4,
    output logic               Stall,
    output logic               ID_EX_Valid,
    output logic [REG_W-1:0]   ID_EX_Rs,
    output logic [REG_W-1:0]   ID_EX_Rt,
    output logic [REG_W-1:0]   ID_EX_Rd,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemtoReg,
    output logic               ID_EX_ALUSrc,
    output logic               ID_EX_Branch,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic [DATA_W-1:0]  ID_EX_ReadData1,
    output logic [DATA_W-1:0]  ID_EX_ReadData2,
    output logic [DATA_W-1:0]  ID_EX_Imm,
    output logic [DATA_W-1:0]  ID_EX_PC4
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]        StallCount
`endif
);

    logic              valid_q;
    id_ex_ctrl_t       ctrl_q;
    id_ex_ctrl_t       ctrl_in;
    logic [REG_W-1:0]  rs_q;
    logic [REG_W-1:0]  rt_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] pc4_q;

    // Hazard check looks at what EX holds now against what ID presents now.
    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_valid    (IF_ID_Valid),
        .id_rs       (IF_ID_Rs),
        .id_rt       (IF_ID_Rt),
        .stall       (Stall)
    );

    // Pack the decoded ID control fields into the bundle that gets registered.
    always_comb begin
        ctrl_in            = CTRL_BUBBLE;
        ctrl_in.reg_write  = ID_RegWrite;
        ctrl_in.mem_read   = ID_MemRead;
        ctrl_in.mem_write  = ID_MemWrite;
        ctrl_in.mem_to_reg = ID_MemtoReg;
        ctrl_in.alu_src    = ID_ALUSrc;
        ctrl_in.branch     = ID_Branch;
        ctrl_in.alu_op     = CTRL_ALUOP_W'(ID_ALUOp);
    end

    // EX register bank: bubble on flush or stall (register numbers zeroed so forwarding never matches), else capture ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
        end else if (Flush || Stall) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
        end else begin
            // Invalid slots are captured as-is; downstream qualifies control with Valid.
            valid_q <= IF_ID_Valid;
            ctrl_q  <= ctrl_in;
            rs_q    <= IF_ID_Rs;
            rt_q    <= IF_ID_Rt;
            rd_q    <= ID_Rd;
            rd1_q   <= ID_ReadData1;
            rd2_q   <= ID_ReadData2;
            imm_q   <= ID_Imm;
            pc4_q   <= ID_PC4;
        end
    end

    assign ID_EX_Valid     = valid_q;
    assign ID_EX_Rs        = rs_q;
    assign ID_EX_Rt        = rt_q;
    assign ID_EX_Rd        = rd_q;
    assign ID_EX_RegWrite  = ctrl_q.reg_write;
    assign ID_EX_MemRead   = ctrl_q.mem_read;
    assign ID_EX_MemWrite  = ctrl_q.mem_write;
    assign ID_EX_MemtoReg  = ctrl_q.mem_to_reg;
    assign ID_EX_ALUSrc    = ctrl_q.alu_src;
    assign ID_EX_Branch    = ctrl_q.branch;
    assign ID_EX_ALUOp     = ALUOP_W'(ctrl_q.alu_op);
    assign ID_EX_ReadData1 = rd1_q;
    assign ID_EX_ReadData2 = rd2_q;
    assign ID_EX_Imm       = imm_q;
    assign ID_EX_PC4       = pc4_q;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    // Count genuine load-use stalls (a flush in the same cycle supersedes the stall); saturate rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (Stall && !Flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule
